useq: RTL and testbench

Microcode sequencer for the 16-bit CPU: the control-side counterpart of the datapath. It fetches instruction words over the shared data bus, decodes them, and drives every register output-enable and load strobe, the PC increment, the ALU operand and result latches, the ALU function, and the memory read/write handshake. It owns the fetch/decode/execute state machine and the carry/zero flags. It guarantees at most one bus driver per cycle.

---
 rtl/useq.sv | 211 +++++++++++++++++++++
 tb/tb_useq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/useq.sv
// Microcode sequencer for the 16-bit CPU: fetch/decode/execute state machine,
// carry/zero flags, and every bus-drive, load and memory-handshake strobe.
module useq #(
    parameter int DATA_BUS_WIDTH = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DATA_BUS_WIDTH-1:0] dataBus,
    input  logic                      aluCout,
    input  logic                      aluZout,
    input  logic                      memReady,
    output logic                      regOE,
    output logic [2:0]                regOESel,
    output logic                      regLoad,
    output logic [2:0]                regLoadSel,
    output logic                      pcInc,
    output logic                      aluBLoad,
    output logic                      aluYLoad,
    output logic                      aluYOE,
    output logic [2:0]                aluF,
    output logic                      marLoad,
    output logic                      memRead,
    output logic                      memWrite,
    output logic                      memOE,
    output logic                      flagC,
    output logic                      flagZ,
    output logic                      halted
);

    localparam logic [3:0] ST_RST     = 4'd0;
    localparam logic [3:0] ST_F_ADDR  = 4'd1;
    localparam logic [3:0] ST_F_WAIT  = 4'd2;
    localparam logic [3:0] ST_F_LATCH = 4'd3;
    localparam logic [3:0] ST_DECODE  = 4'd4;
    localparam logic [3:0] ST_A_B     = 4'd5;
    localparam logic [3:0] ST_A_A     = 4'd6;
    localparam logic [3:0] ST_A_WB    = 4'd7;
    localparam logic [3:0] ST_MOV     = 4'd8;
    localparam logic [3:0] ST_L_ADDR  = 4'd9;
    localparam logic [3:0] ST_L_WAIT  = 4'd10;
    localparam logic [3:0] ST_L_LATCH = 4'd11;
    localparam logic [3:0] ST_S_ADDR  = 4'd12;
    localparam logic [3:0] ST_S_WR    = 4'd13;
    localparam logic [3:0] ST_JMP     = 4'd14;
    localparam logic [3:0] ST_HALT    = 4'd15;

    localparam logic [2:0] REG_PC = 3'd7;

    logic [3:0]                state_q, state_d;
    logic [DATA_BUS_WIDTH-1:0] ir_q, ir_d;
    logic                      flag_c_q, flag_c_d;
    logic                      flag_z_q, flag_z_d;

    logic [3:0] op;
    logic [2:0] fld_d, fld_a, fld_b;
    logic       ir_unused;

    assign op        = ir_q[15:12];
    assign fld_d     = ir_q[11:9];
    assign fld_a     = ir_q[8:6];
    assign fld_b     = ir_q[5:3];
    assign ir_unused = ^ir_q[2:0];

    // NOTE: every variable gets a default at the top of a combinational block,
    // so no path through the case statement can leave it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        flag_c_d = flag_c_q;
        flag_z_d = flag_z_q;
        case (state_q)
            ST_RST:     state_d = ST_F_ADDR;
            ST_F_ADDR:  state_d = ST_F_WAIT;
            ST_F_WAIT:  if (memReady) state_d = ST_F_LATCH;
            ST_F_LATCH: begin
                ir_d    = dataBus;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (!op[3]) begin
                    state_d = ST_A_B;
                end else begin
                    case (op[2:0])
                        3'b000:  state_d = ST_MOV;
                        3'b001:  state_d = ST_L_ADDR;
                        3'b010:  state_d = ST_S_ADDR;
                        3'b011:  state_d = ST_JMP;
                        3'b100:  state_d = flag_z_q ? ST_JMP : ST_F_ADDR;
                        3'b101:  state_d = flag_c_q ? ST_JMP : ST_F_ADDR;
                        3'b110:  state_d = ST_F_ADDR;
                        default: state_d = ST_HALT;
                    endcase
                end
            end
            ST_A_B:     state_d = ST_A_A;
            ST_A_A: begin
                flag_c_d = aluCout;
                flag_z_d = aluZout;
                state_d  = ST_A_WB;
            end
            ST_A_WB:    state_d = ST_F_ADDR;
            ST_MOV:     state_d = ST_F_ADDR;
            ST_L_ADDR:  state_d = ST_L_WAIT;
            ST_L_WAIT:  if (memReady) state_d = ST_L_LATCH;
            ST_L_LATCH: state_d = ST_F_ADDR;
            ST_S_ADDR:  state_d = ST_S_WR;
            ST_S_WR:    if (memReady) state_d = ST_F_ADDR;
            ST_JMP:     state_d = ST_F_ADDR;
            ST_HALT:    state_d = ST_HALT;
            default:    state_d = ST_RST;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_RST;
            ir_q     <= '0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            flag_c_q <= flag_c_d;
            flag_z_q <= flag_z_d;
        end
    end

    // Moore decode: strobes depend only on the current state and the IR.
    always_comb begin
        regOE      = 1'b0;
        regOESel   = 3'd0;
        regLoad    = 1'b0;
        regLoadSel = 3'd0;
        pcInc      = 1'b0;
        aluBLoad   = 1'b0;
        aluYLoad   = 1'b0;
        aluYOE     = 1'b0;
        aluF       = 3'd0;
        marLoad    = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        memOE      = 1'b0;
        halted     = 1'b0;
        case (state_q)
            ST_F_ADDR: begin
                regOE    = 1'b1;
                regOESel = REG_PC;
                marLoad  = 1'b1;
            end
            ST_F_WAIT:  memRead = 1'b1;
            ST_F_LATCH: begin
                memRead = 1'b1;
                memOE   = 1'b1;
                pcInc   = 1'b1;
            end
            ST_A_B: begin
                regOE    = 1'b1;
                regOESel = fld_b;
                aluBLoad = 1'b1;
            end
            ST_A_A: begin
                regOE    = 1'b1;
                regOESel = fld_a;
                aluYLoad = 1'b1;
                aluF     = op[2:0];
            end
            ST_A_WB: begin
                aluYOE     = 1'b1;
                regLoad    = 1'b1;
                regLoadSel = fld_d;
            end
            ST_MOV: begin
                regOE      = 1'b1;
                regOESel   = fld_a;
                regLoad    = 1'b1;
                regLoadSel = fld_d;
            end
            ST_L_ADDR, ST_S_ADDR: begin
                regOE    = 1'b1;
                regOESel = fld_a;
                marLoad  = 1'b1;
            end
            ST_L_WAIT:  memRead = 1'b1;
            ST_L_LATCH: begin
                memRead    = 1'b1;
                memOE      = 1'b1;
                regLoad    = 1'b1;
                regLoadSel = fld_d;
            end
            ST_S_WR: begin
                regOE    = 1'b1;
                regOESel = fld_b;
                memWrite = 1'b1;
            end
            ST_JMP: begin
                regOE      = 1'b1;
                regOESel   = fld_a;
                regLoad    = 1'b1;
                regLoadSel = REG_PC;
            end
            ST_HALT:    halted = 1'b1;
            default:    ;
        endcase
    end

    assign flagC = flag_c_q;
    assign flagZ = flag_z_q;

endmodule

// File: tb/tb_useq.sv
// Self-checking bench for useq: each instruction is expanded into its expected
// per-cycle strobe trace from the instruction's bus transactions and replayed.
module tb_useq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] dataBus = '0;
    logic        aluCout = 1'b0;
    logic        aluZout = 1'b0;
    logic        memReady = 1'b0;
    logic        regOE, regLoad, pcInc, aluBLoad, aluYLoad, aluYOE, marLoad;
    logic        memRead, memWrite, memOE, flagC, flagZ, halted;
    logic [2:0]  regOESel, regLoadSel, aluF;

    always #5 clock = ~clock;

    useq #(.DATA_BUS_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .dataBus(dataBus),
        .aluCout(aluCout), .aluZout(aluZout), .memReady(memReady),
        .regOE(regOE), .regOESel(regOESel), .regLoad(regLoad), .regLoadSel(regLoadSel),
        .pcInc(pcInc), .aluBLoad(aluBLoad), .aluYLoad(aluYLoad), .aluYOE(aluYOE),
        .aluF(aluF), .marLoad(marLoad), .memRead(memRead), .memWrite(memWrite),
        .memOE(memOE), .flagC(flagC), .flagZ(flagZ), .halted(halted)
    );

    typedef struct packed {
        logic       reg_oe;
        logic [2:0] reg_oe_sel;
        logic       reg_load;
        logic [2:0] reg_load_sel;
        logic       pc_inc;
        logic       alu_b_load;
        logic       alu_y_load;
        logic       alu_y_oe;
        logic [2:0] alu_f;
        logic       mar_load;
        logic       mem_read;
        logic       mem_write;
        logic       mem_oe;
        logic       flag_c;
        logic       flag_z;
        logic       halted;
    } outs_t;

    typedef struct {
        outs_t exp;
        bit    mr;
        bit    c;
        bit    z;
        bit    latch;
    } entry_t;

    entry_t      trace_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    bit          m_c = 1'b0;
    bit          m_z = 1'b0;
    logic [15:0] cur_ir = '0;

    function automatic outs_t observed();
        outs_t o;
        o.reg_oe = regOE;       o.reg_oe_sel = regOESel;
        o.reg_load = regLoad;   o.reg_load_sel = regLoadSel;
        o.pc_inc = pcInc;       o.alu_b_load = aluBLoad;
        o.alu_y_load = aluYLoad; o.alu_y_oe = aluYOE;
        o.alu_f = aluF;         o.mar_load = marLoad;
        o.mem_read = memRead;   o.mem_write = memWrite;
        o.mem_oe = memOE;       o.flag_c = flagC;
        o.flag_z = flagZ;       o.halted = halted;
        return o;
    endfunction

    function automatic bit rbit();
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic push(input outs_t o, input bit mr, input bit c, input bit z, input bit latch);
        entry_t e;
        o.flag_c = m_c;
        o.flag_z = m_z;
        e.exp = o; e.mr = mr; e.c = c; e.z = z; e.latch = latch;
        trace_q.push_back(e);
    endtask

    // Memory wait: memReady low for 'stall' cycles, then high on the last one.
    task automatic push_wait(input outs_t o, input int stall);
        for (int i = 0; i < stall; i++) push(o, 1'b0, rbit(), rbit(), 1'b0);
        push(o, 1'b1, rbit(), rbit(), 1'b0);
    endtask

    // Expected trace for one instruction; c/z are the ALU results presented
    // while the ALU result is latched.
    task automatic build(input logic [15:0] ir, input int fstall, input int xstall,
                         input bit c, input bit z, input int halt_cycles);
        logic [2:0] d, a, b;
        outs_t o;
        d = ir[11:9]; a = ir[8:6]; b = ir[5:3];
        cur_ir = ir;
        o = '0; o.reg_oe = 1; o.reg_oe_sel = 3'd7; o.mar_load = 1;
        push(o, rbit(), rbit(), rbit(), 1'b0);
        o = '0; o.mem_read = 1;
        push_wait(o, fstall);
        o = '0; o.mem_read = 1; o.mem_oe = 1; o.pc_inc = 1;
        push(o, rbit(), rbit(), rbit(), 1'b1);
        o = '0;
        push(o, rbit(), rbit(), rbit(), 1'b0);
        if (!ir[15]) begin
            o = '0; o.reg_oe = 1; o.reg_oe_sel = b; o.alu_b_load = 1;
            push(o, rbit(), rbit(), rbit(), 1'b0);
            o = '0; o.reg_oe = 1; o.reg_oe_sel = a; o.alu_y_load = 1; o.alu_f = ir[14:12];
            push(o, rbit(), c, z, 1'b0);
            m_c = c; m_z = z;
            o = '0; o.alu_y_oe = 1; o.reg_load = 1; o.reg_load_sel = d;
            push(o, rbit(), rbit(), rbit(), 1'b0);
        end else begin
            case (ir[14:12])
                3'd0: begin
                    o = '0; o.reg_oe = 1; o.reg_oe_sel = a; o.reg_load = 1; o.reg_load_sel = d;
                    push(o, rbit(), rbit(), rbit(), 1'b0);
                end
                3'd1: begin
                    o = '0; o.reg_oe = 1; o.reg_oe_sel = a; o.mar_load = 1;
                    push(o, rbit(), rbit(), rbit(), 1'b0);
                    o = '0; o.mem_read = 1;
                    push_wait(o, xstall);
                    o = '0; o.mem_read = 1; o.mem_oe = 1; o.reg_load = 1; o.reg_load_sel = d;
                    push(o, rbit(), rbit(), rbit(), 1'b0);
                end
                3'd2: begin
                    o = '0; o.reg_oe = 1; o.reg_oe_sel = a; o.mar_load = 1;
                    push(o, rbit(), rbit(), rbit(), 1'b0);
                    o = '0; o.reg_oe = 1; o.reg_oe_sel = b; o.mem_write = 1;
                    push_wait(o, xstall);
                end
                3'd3, 3'd4, 3'd5: begin
                    if (ir[14:12] == 3'd3 || (ir[14:12] == 3'd4 && m_z) ||
                        (ir[14:12] == 3'd5 && m_c)) begin
                        o = '0; o.reg_oe = 1; o.reg_oe_sel = a; o.reg_load = 1;
                        o.reg_load_sel = 3'd7;
                        push(o, rbit(), rbit(), rbit(), 1'b0);
                    end
                end
                3'd6: ;
                default: begin
                    o = '0; o.halted = 1;
                    for (int i = 0; i < halt_cycles; i++) push(o, rbit(), rbit(), rbit(), 1'b0);
                end
            endcase
        end
    endtask

    // Called at a falling edge: check this cycle's outputs, drive next inputs.
    task automatic apply(input entry_t e, input string name);
        outs_t got;
        int    drivers;
        got = observed();
        vectors++;
        if (got !== e.exp) begin
            miscompares++;
            $display("FAIL %s strobes ir=%h: got %h required %h", name, cur_ir, got, e.exp);
        end
        drivers = int'(regOE) + int'(aluYOE) + int'(memOE);
        vectors++;
        if (drivers > 1) begin
            miscompares++;
            $display("FAIL %s bus_drivers: got %0d required <=1", name, drivers);
        end
        dataBus  = e.latch ? cur_ir : 16'($urandom);
        memReady = e.mr;
        aluCout  = e.c;
        aluZout  = e.z;
        @(negedge clock);
    endtask

    task automatic run_n(input string name, input int n);
        for (int i = 0; i < n && trace_q.size() > 0; i++) apply(trace_q.pop_front(), name);
    endtask

    task automatic run_all(input string name);
        while (trace_q.size() > 0) apply(trace_q.pop_front(), name);
    endtask

    task automatic check_zero(input string name);
        outs_t got;
        got = observed();
        vectors++;
        if (got !== outs_t'('0)) begin
            miscompares++;
            $display("FAIL %s all_zero: got %h required 0", name, got);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check_zero("reset");
        end
        reset = 1'b0;
        m_c = 1'b0;
        m_z = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_alu();
        build(16'h0298, 0, 0, 1'b1, 1'b0, 0);
        run_all("alu_0298");
    endtask

    task automatic test_load_stall();
        build(16'h9480, 0, 3, 1'b0, 1'b0, 0);
        run_all("load_stall");
    endtask

    task automatic test_jz();
        build(16'h1298, 1, 0, 1'b0, 1'b1, 0);
        run_all("jz_pre_alu_z1");
        build(16'hC0C0, 0, 0, 1'b0, 1'b0, 0);
        run_all("jz_taken");
        build(16'h2298, 0, 0, 1'b1, 1'b0, 0);
        run_all("jz_pre_alu_z0");
        build(16'hC0C0, 0, 0, 1'b0, 1'b0, 0);
        run_all("jz_not_taken");
        build(16'hD0C0, 2, 0, 1'b0, 1'b0, 0);
        run_all("jc_taken");
    endtask

    task automatic test_reset_in_store();
        entry_t e;
        outs_t  got;
        build(16'h3298, 0, 0, 1'b1, 1'b1, 0);
        run_all("store_pre_alu");
        build(16'hA0D8, 0, 5, 1'b0, 1'b0, 0);
        run_n("store_reset", 5);
        e = trace_q.pop_front();
        got = observed();
        vectors++;
        if (got !== e.exp) begin
            miscompares++;
            $display("FAIL store_reset s_wr: got %h required %h", got, e.exp);
        end
        trace_q.delete();
        memReady = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check_zero("store_reset");
        reset = 1'b0;
        m_c = 1'b0;
        m_z = 1'b0;
        @(negedge clock);
        build(16'hE000, 0, 0, 1'b0, 1'b0, 0);
        run_all("after_reset_nop");
    endtask

    task automatic test_random();
        logic [15:0] ir;
        for (int n = 0; n < 80; n++) begin
            ir = 16'($urandom);
            if (ir[15:12] == 4'hF) ir[15:12] = 4'hE;
            build(ir, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  rbit(), rbit(), 0);
            run_all("random");
        end
    endtask

    task automatic test_halt();
        build(16'hF000, 1, 0, 1'b0, 1'b0, 20);
        run_all("halt");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_stall();
        test_jz();
        test_reset_in_store();
        test_random();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
